// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_arb_pkg
//  Description : Shared types and helpers for the FIFO write-port arbiter.
//                - arb_state_t : arbiter state encoding (IDLE / GRANT)
//                - STAT_W      : width of the optional per-requester counters
//                - idx_width() : requester index width, clog2(n) with a
//                                minimum of 1 bit
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns the first set bit
//                of 'valid' at or after 'start' (wrapping modulo NREQ),
//                optionally ignoring one index.
//  Ports       : valid    in  NREQ  candidate vector
//                start    in  IW    first index to consider
//                excl_en  in  1     enable exclusion of excl_idx
//                excl_idx in  IW    index to skip when excl_en=1
//                found    out 1     at least one eligible candidate
//                winner   out IW    selected index (0 when found=0)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   start,
    input  logic            excl_en,
    input  logic [IW-1:0]   excl_idx,
    output logic            found,
    output logic [IW-1:0]   winner
);

    logic [NREQ-1:0] w_excl_mask;
    logic [NREQ-1:0] w_masked;
    logic [IW:0]     w_pos;

    assign w_excl_mask = excl_en ? (NREQ'(1) << excl_idx) : '0;
    assign w_masked    = valid & ~w_excl_mask;

    // Walk offsets from the far end toward 'start' so the last hit written
    // is the closest one to 'start' in round-robin order.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        w_pos  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = {1'b0, start} + (IW + 1)'(k);
            if (w_pos >= (IW + 1)'(NREQ)) begin
                w_pos = w_pos - (IW + 1)'(NREQ);
            end
            if (w_masked[w_pos[IW-1:0]]) begin
                found  = 1'b1;
                winner = w_pos[IW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin arbiter sharing one synchronous FIFO write port
//                among NREQ valid/ready producers. A grant is registered one
//                cycle after a request, held for at most BURST_MAX words, and
//                no write is issued while the FIFO is full.
//  Ports       : clock, reset (sync, active-high)
//                req_valid/req_data/req_ready : producer handshakes
//                fifo_full/fifo_wn/fifo_datain : FIFO write port
//                grant_valid/grant_id          : current grant holder
//                stat_sel/stat_count           : accepted-word counters,
//                                                only with FIFO_ARB_STATS_EN
//  Options     : `define FIFO_ARB_STATS_EN to add 16-bit saturating
//                per-requester accepted-word counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = 32,
    parameter int BURST_MAX = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*DW-1:0]           req_data,
    output logic [NREQ-1:0]              req_ready,
    input  logic                         fifo_full,
    output logic                         fifo_wn,
    output logic [DW-1:0]                fifo_datain,
    output logic                         grant_valid,
    output logic [idx_width(NREQ)-1:0]   grant_id
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic [idx_width(NREQ)-1:0]   stat_sel,
    output logic [STAT_W-1:0]            stat_count
`endif
);

    localparam int             c_iw         = idx_width(NREQ);
    localparam logic [c_iw-1:0] c_last_idx  = c_iw'(NREQ - 1);
    localparam logic [3:0]      c_burst_last = 4'(BURST_MAX - 1);

    arb_state_t      r_state;
    logic [c_iw-1:0] r_grant_id;
    logic [c_iw-1:0] r_last_ptr;
    logic [3:0]      r_burst_cnt;

    logic            w_in_grant;
    logic            w_holder_valid;
    logic            w_xfer;
    logic            w_burst_rel;
    logic            w_release;
    logic [c_iw-1:0] w_start;
    logic            w_found;
    logic [c_iw-1:0] w_winner;

    function automatic logic [c_iw-1:0] f_next(input logic [c_iw-1:0] p);
        return (p == c_last_idx) ? '0 : p + 1'b1;
    endfunction

    assign w_in_grant     = (r_state == GRANT);
    assign w_holder_valid = req_valid[r_grant_id];
    assign w_xfer         = w_in_grant & w_holder_valid & ~fifo_full & ~reset;
    assign w_burst_rel    = w_xfer & (r_burst_cnt == c_burst_last);
    assign w_release      = w_in_grant & (~w_holder_valid | w_burst_rel);

    // One picker serves both paths: from IDLE the search starts after the
    // last released holder; from GRANT it starts after the current holder.
    assign w_start = w_in_grant ? f_next(r_grant_id) : f_next(r_last_ptr);

    rr_pick #(
        .NREQ (NREQ),
        .IW   (c_iw)
    ) u_pick (
        .valid    (req_valid),
        .start    (w_start),
        .excl_en  (w_burst_rel),
        .excl_idx (r_grant_id),
        .found    (w_found),
        .winner   (w_winner)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant_id  <= '0;
            r_last_ptr  <= c_last_idx;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state     <= GRANT;
                        r_grant_id  <= w_winner;
                        r_burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_last_ptr  <= r_grant_id;
                        r_burst_cnt <= '0;
                        if (w_found) begin
                            r_grant_id <= w_winner;
                        end else if (!w_burst_rel) begin
                            r_state <= IDLE;
                        end
                        // Burst release with no other candidate: the holder
                        // keeps the grant with a fresh burst count.
                    end else if (w_xfer) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready   = '0;
        fifo_datain = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_in_grant && (r_grant_id == c_iw'(i))) begin
                req_ready[i] = ~fifo_full & ~reset;
                fifo_datain  = req_data[i*DW +: DW];
            end
        end
    end

    assign fifo_wn     = w_xfer;
    assign grant_valid = w_in_grant;
    assign grant_id    = r_grant_id;

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat_cnt [NREQ];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                r_stat_cnt[i] <= '0;
            end
        end else if (w_xfer && (r_stat_cnt[r_grant_id] != '1)) begin
            r_stat_cnt[r_grant_id] <= r_stat_cnt[r_grant_id] + 1'b1;
        end
    end

    assign stat_count = r_stat_cnt[stat_sel];
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Directed self-checking bench for fifo_wr_arbiter
//                (NREQ=4, DW=32, BURST_MAX=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_full;
    logic              fifo_wn;
    logic [DW-1:0]     fifo_datain;
    logic              grant_valid;
    logic [1:0]        grant_id;
`ifdef FIFO_ARB_STATS_EN
    logic [1:0]        stat_sel;
    logic [15:0]       stat_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .BURST_MAX (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wn     (fifo_wn),
        .fifo_datain (fifo_datain),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_sel    (stat_sel),
        .stat_count  (stat_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic gv, input logic [1:0] gid,
                           input logic wn, input logic [3:0] rdy, input logic [31:0] dat);
        chk({tag, ".grant_valid"}, 64'(grant_valid), 64'(gv));
        if (gv) chk({tag, ".grant_id"}, 64'(grant_id), 64'(gid));
        chk({tag, ".fifo_wn"},     64'(fifo_wn),     64'(wn));
        chk({tag, ".req_ready"},   64'(req_ready),   64'(rdy));
        chk({tag, ".fifo_datain"}, 64'(fifo_datain), 64'(dat));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_data(input int i, input logic [31:0] d);
        req_data[i*DW +: DW] = d;
    endtask

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        stat_sel  = '0;
`endif
        tick();
        tick();
        chk_out("rst", 1'b0, 2'd0, 1'b0, 4'b0000, 32'd0);

        // ---- single requester, two words, then drop ----
        reset = 1'b0;
        set_data(0, 32'd100);
        req_valid = 4'b0001;
        settle();
        chk_out("t1_req", 1'b0, 2'd0, 1'b0, 4'b0000, 32'd0);
        tick();
        chk_out("t1_w1", 1'b1, 2'd0, 1'b1, 4'b0001, 32'd100);
        tick();
        set_data(0, 32'd150);
        settle();
        chk_out("t1_w2", 1'b1, 2'd0, 1'b1, 4'b0001, 32'd150);
        tick();
        req_valid = 4'b0000;
        settle();
        chk_out("t1_drop", 1'b1, 2'd0, 1'b0, 4'b0001, 32'd150);
        tick();
        chk_out("t1_idle", 1'b0, 2'd0, 1'b0, 4'b0000, 32'd0);

        // ---- all requesters, bursts of 4 rotate 0,1,2,3,0 ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_data(i, 32'hA0 + 32'(i));
        req_valid = 4'b1111;
        settle();
        tick();
        for (int b = 0; b < 5; b++) begin
            for (int w = 0; w < 4; w++) begin
                chk_out($sformatf("t2_b%0d_w%0d", b, w), 1'b1, 2'(b % 4), 1'b1,
                        4'(1 << (b % 4)), 32'hA0 + 32'(b % 4));
                tick();
            end
        end
        req_valid = 4'b0000;
        settle();
        chk_out("t2_stop", 1'b1, 2'd1, 1'b0, 4'b0010, 32'hA1);
        tick();
        chk_out("t2_idle", 1'b0, 2'd0, 1'b0, 4'b0000, 32'd0);

        // ---- req 2 granted, FIFO full for 3 cycles, req 3 waiting ----
        set_data(2, 32'h200);
        set_data(3, 32'h300);
        req_valid = 4'b1100;
        settle();
        tick();
        chk_out("t3_g", 1'b1, 2'd2, 1'b1, 4'b0100, 32'h200);
        tick();
        fifo_full = 1'b1;
        settle();
        for (int c = 0; c < 3; c++) begin
            chk_out($sformatf("t3_full%0d", c), 1'b1, 2'd2, 1'b0, 4'b0000, 32'h200);
            tick();
        end
        fifo_full = 1'b0;
        settle();
        for (int c = 0; c < 3; c++) begin
            chk_out($sformatf("t3_res%0d", c), 1'b1, 2'd2, 1'b1, 4'b0100, 32'h200);
            tick();
        end
        chk_out("t3_rot", 1'b1, 2'd3, 1'b1, 4'b1000, 32'h300);

        // ---- move the grant to req 1 with last_ptr=0, reset mid-burst ----
        set_data(0, 32'h10);
        set_data(1, 32'h11);
        req_valid = 4'b0001;
        settle();
        chk_out("t4_drop3", 1'b1, 2'd3, 1'b0, 4'b1000, 32'h300);
        tick();
        chk_out("t4_g0", 1'b1, 2'd0, 1'b1, 4'b0001, 32'h10);
        req_valid = 4'b0010;
        settle();
        chk_out("t4_drop0", 1'b1, 2'd0, 1'b0, 4'b0001, 32'h10);
        tick();
        chk_out("t4_g1", 1'b1, 2'd1, 1'b1, 4'b0010, 32'h11);
        tick();
        tick();
        chk_out("t4_b2", 1'b1, 2'd1, 1'b1, 4'b0010, 32'h11);
        reset = 1'b1;
        settle();
        chk_out("t4_rstforce", 1'b1, 2'd1, 1'b0, 4'b0000, 32'h11);
        tick();
        reset = 1'b0;
        req_valid = 4'b0011;
        settle();
        chk_out("t4_post", 1'b0, 2'd0, 1'b0, 4'b0000, 32'd0);
        tick();
        chk_out("t4_first", 1'b1, 2'd0, 1'b1, 4'b0001, 32'h10);

        // ---- only req 3: back-to-back re-grants, continuous writes ----
        req_valid = 4'b1000;
        settle();
        chk_out("t5_drop0", 1'b1, 2'd0, 1'b0, 4'b0001, 32'h10);
        tick();
        for (int c = 0; c < 12; c++) begin
            chk_out($sformatf("t5_w%0d", c), 1'b1, 2'd3, 1'b1, 4'b1000, 32'h300);
            tick();
        end
        req_valid = 4'b0000;
        settle();
        tick();
        chk_out("t5_idle", 1'b0, 2'd0, 1'b0, 4'b0000, 32'd0);

`ifdef FIFO_ARB_STATS_EN
        // ---- counters: 5 words from req 0, 3 from req 2 ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 4'b0001;
        settle();
        tick();
        for (int c = 0; c < 5; c++) tick();
        req_valid = 4'b0100;
        settle();
        tick();
        for (int c = 0; c < 3; c++) tick();
        req_valid = 4'b0000;
        settle();
        tick();
        stat_sel = 2'd0;
        settle();
        chk("st_0", 64'(stat_count), 64'd5);
        stat_sel = 2'd1;
        settle();
        chk("st_1", 64'(stat_count), 64'd0);
        stat_sel = 2'd2;
        settle();
        chk("st_2", 64'(stat_count), 64'd3);
        stat_sel = 2'd3;
        settle();
        chk("st_3", 64'(stat_count), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
